// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths, MEM/WB payload layout and skid-buffer states
package pipe_pkg;

    localparam int INT_W    = 32;
    localparam int RADDR_W  = 5;
    localparam int WRCTRL_W = 2;
    localparam int FP_W     = 64;
    localparam int CNT_W    = 16;

    // Payload is packed MSB->LSB as {alu_result, mem_data, rw, wr_ctrl, fp_bus_w, fp_reg_wr}
    function automatic int memwb_payload_w(input int int_w, input int raddr_w,
                                           input int wrctrl_w, input int fp_w);
        return 2*int_w + raddr_w + wrctrl_w + fp_w + 1;
    endfunction

    localparam int MEMWB_OFF_FP_WR  = 0;
    localparam int MEMWB_OFF_FP_BUS = 1;

    function automatic int memwb_off_wr_ctrl(input int fp_w);
        return MEMWB_OFF_FP_BUS + fp_w;
    endfunction

    function automatic int memwb_off_rw(input int fp_w, input int wrctrl_w);
        return memwb_off_wr_ctrl(fp_w) + wrctrl_w;
    endfunction

    function automatic int memwb_off_mem(input int fp_w, input int wrctrl_w, input int raddr_w);
        return memwb_off_rw(fp_w, wrctrl_w) + raddr_w;
    endfunction

    function automatic int memwb_off_alu(input int fp_w, input int wrctrl_w, input int raddr_w,
                                         input int int_w);
        return memwb_off_mem(fp_w, wrctrl_w, raddr_w) + int_w;
    endfunction

    localparam int MEMWB_PAYLOAD_W = 2*INT_W + RADDR_W + WRCTRL_W + FP_W + 1;

    // Occupancy of a two-entry stage: main only, or main plus skid
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - valid/ready pipeline register with optional skid entry and flush
module pipe_skid_buf #(
    parameter int W       = 8,
    parameter bit SKID_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    import pipe_pkg::*;

    generate
        if (SKID_EN) begin : g_skid
            skid_state_t  state;
            logic [W-1:0] main_q;
            logic [W-1:0] skid_q;
            logic         valid_q;
            logic         skid_valid_q;

            // Occupancy FSM; in_ready comes straight from the registered skid flag
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state        <= SKID_EMPTY;
                    main_q       <= '0;
                    skid_q       <= '0;
                    valid_q      <= 1'b0;
                    skid_valid_q <= 1'b0;
                end else if (flush) begin
                    state        <= SKID_EMPTY;
                    valid_q      <= 1'b0;
                    skid_valid_q <= 1'b0;
                end else begin
                    case (state)
                        SKID_EMPTY: begin
                            if (in_valid) begin
                                main_q  <= in_data;
                                valid_q <= 1'b1;
                                state   <= SKID_ONE;
                            end
                        end
                        SKID_ONE: begin
                            if (in_valid && out_ready) begin
                                main_q <= in_data;
                            end else if (in_valid) begin
                                skid_q       <= in_data;
                                skid_valid_q <= 1'b1;
                                state        <= SKID_TWO;
                            end else if (out_ready) begin
                                valid_q <= 1'b0;
                                state   <= SKID_EMPTY;
                            end
                        end
                        SKID_TWO: begin
                            if (out_ready) begin
                                main_q       <= skid_q;
                                skid_valid_q <= 1'b0;
                                state        <= SKID_ONE;
                            end
                        end
                        default: begin
                            valid_q      <= 1'b0;
                            skid_valid_q <= 1'b0;
                            state        <= SKID_EMPTY;
                        end
                    endcase
                end
            end

            assign in_ready  = !skid_valid_q;
            assign out_valid = valid_q;
            assign out_data  = main_q;
        end else begin : g_single
            logic [W-1:0] main_q;
            logic         valid_q;

            // Single entry: refill in the same cycle the consumer drains it
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    main_q  <= '0;
                    valid_q <= 1'b0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (in_valid && in_ready) begin
                    main_q  <= in_data;
                    valid_q <= 1'b1;
                end else if (out_ready) begin
                    valid_q <= 1'b0;
                end
            end

            assign in_ready  = !valid_q || out_ready;
            assign out_valid = valid_q;
            assign out_data  = main_q;
        end
    endgenerate

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// rtl/mem_wb_pipe_stage.sv - MEM->WB stage: payload pack/unpack, bubble-safe write controls, perf counters
module mem_wb_pipe_stage #(
    parameter int INT_W    = pipe_pkg::INT_W,
    parameter int RADDR_W  = pipe_pkg::RADDR_W,
    parameter int WRCTRL_W = pipe_pkg::WRCTRL_W,
    parameter int FP_W     = pipe_pkg::FP_W,
    parameter bit SKID_EN  = 1'b1,
    parameter int CNT_W    = pipe_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INT_W-1:0]    alu_result_mem,
    input  logic [INT_W-1:0]    mem_data_mem,
    input  logic [RADDR_W-1:0]  rw_mem,
    input  logic [WRCTRL_W-1:0] wr_ctrl_mem,
    input  logic [FP_W-1:0]     fp_bus_w_mem,
    input  logic                fp_reg_wr_mem,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INT_W-1:0]    alu_result_wb,
    output logic [INT_W-1:0]    mem_data_wb,
    output logic [RADDR_W-1:0]  rw_wb,
    output logic [WRCTRL_W-1:0] wr_ctrl_wb,
    output logic [FP_W-1:0]     fp_bus_w_wb,
    output logic                fp_reg_wr_wb,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    bubble_cnt,
    output logic [CNT_W-1:0]    stall_cnt
);
    import pipe_pkg::*;

    localparam int PAY_W   = memwb_payload_w(INT_W, RADDR_W, WRCTRL_W, FP_W);
    localparam int OFF_WC  = memwb_off_wr_ctrl(FP_W);
    localparam int OFF_RW  = memwb_off_rw(FP_W, WRCTRL_W);
    localparam int OFF_MEM = memwb_off_mem(FP_W, WRCTRL_W, RADDR_W);
    localparam int OFF_ALU = memwb_off_alu(FP_W, WRCTRL_W, RADDR_W, INT_W);

    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;
    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W-1:0] stall_q;

    assign pay_in = {alu_result_mem, mem_data_mem, rw_mem, wr_ctrl_mem, fp_bus_w_mem, fp_reg_wr_mem};

    pipe_skid_buf #(
        .W       (PAY_W),
        .SKID_EN (SKID_EN)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    // Data fields pass through as stored; write enables are forced off in a bubble
    assign alu_result_wb = pay_out[OFF_ALU +: INT_W];
    assign mem_data_wb   = pay_out[OFF_MEM +: INT_W];
    assign rw_wb         = pay_out[OFF_RW +: RADDR_W];
    assign fp_bus_w_wb   = pay_out[MEMWB_OFF_FP_BUS +: FP_W];
    assign wr_ctrl_wb    = pay_out[OFF_WC +: WRCTRL_W] & {WRCTRL_W{out_valid}};
    assign fp_reg_wr_wb  = pay_out[MEMWB_OFF_FP_WR] & out_valid;

    // Saturating bubble/stall counters; flush cycles are not attributed to either
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_q <= '0;
            stall_q  <= '0;
        end else begin
            if (cnt_clr) begin
                bubble_q <= '0;
            end else if (!flush && !out_valid && (bubble_q != {CNT_W{1'b1}})) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
            if (cnt_clr) begin
                stall_q <= '0;
            end else if (!flush && out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign bubble_cnt = bubble_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// tb/tb_mem_wb_pipe_stage.sv - self-checking bench for mem_wb_pipe_stage (skid and single-entry builds)
module tb_mem_wb_pipe_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rw;
        logic [1:0]  wc;
        logic [63:0] fp;
        logic        fpw;
    } pay_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic cnt_clr = 1'b0;
    pay_t in_pay = '0;

    logic        in_ready1, out_valid1, fpw1, in_ready0, out_valid0, fpw0;
    logic [31:0] alu1, mem1, alu0, mem0;
    logic [4:0]  rw1, rw0;
    logic [1:0]  wc1, wc0;
    logic [63:0] fp1, fp0;
    logic [15:0] bub1, stl1, bub0, stl0;
    pay_t        out1, out0;

    assign out1 = {alu1, mem1, rw1, wc1, fp1, fpw1};
    assign out0 = {alu0, mem0, rw0, wc0, fp0, fpw0};

    int tests = 0;
    int fails = 0;

    // Reference model: each stage is a FIFO of fixed capacity plus two saturating tallies
    pay_t q1[$];
    pay_t q0[$];
    int   mb1, ms1, mb0, ms0;

    always #5 clk = ~clk;

    mem_wb_pipe_stage #(.SKID_EN(1'b1)) dut1 (
        .clk(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .alu_result_mem(in_pay.alu), .mem_data_mem(in_pay.mem), .rw_mem(in_pay.rw),
        .wr_ctrl_mem(in_pay.wc), .fp_bus_w_mem(in_pay.fp), .fp_reg_wr_mem(in_pay.fpw),
        .out_valid(out_valid1), .out_ready(out_ready),
        .alu_result_wb(alu1), .mem_data_wb(mem1), .rw_wb(rw1), .wr_ctrl_wb(wc1),
        .fp_bus_w_wb(fp1), .fp_reg_wr_wb(fpw1),
        .cnt_clr(cnt_clr), .bubble_cnt(bub1), .stall_cnt(stl1)
    );

    mem_wb_pipe_stage #(.SKID_EN(1'b0)) dut0 (
        .clk(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .alu_result_mem(in_pay.alu), .mem_data_mem(in_pay.mem), .rw_mem(in_pay.rw),
        .wr_ctrl_mem(in_pay.wc), .fp_bus_w_mem(in_pay.fp), .fp_reg_wr_mem(in_pay.fpw),
        .out_valid(out_valid0), .out_ready(out_ready),
        .alu_result_wb(alu0), .mem_data_wb(mem0), .rw_wb(rw0), .wr_ctrl_wb(wc0),
        .fp_bus_w_wb(fp0), .fp_reg_wr_wb(fpw0),
        .cnt_clr(cnt_clr), .bubble_cnt(bub0), .stall_cnt(stl0)
    );

    function automatic pay_t rand_pay();
        pay_t p;
        p = {$urandom(), $urandom(), 5'($urandom()), 2'($urandom()), $urandom(), $urandom(), 1'($urandom())};
        return p;
    endfunction

    task automatic model_reset();
        q1.delete();
        q0.delete();
        mb1 = 0; ms1 = 0; mb0 = 0; ms0 = 0;
    endtask

    // Advance the model on the current inputs, then step the clock to 1 unit past the edge
    task automatic tick();
        bit v1, r1, v0, r0;
        v1 = q1.size() > 0;
        r1 = q1.size() < 2;
        v0 = q0.size() > 0;
        r0 = (q0.size() == 0) || out_ready;
        if (cnt_clr) begin
            mb1 = 0; ms1 = 0; mb0 = 0; ms0 = 0;
        end else if (!flush) begin
            if (!v1 && mb1 < 65535) mb1++;
            if (v1 && !out_ready && ms1 < 65535) ms1++;
            if (!v0 && mb0 < 65535) mb0++;
            if (v0 && !out_ready && ms0 < 65535) ms0++;
        end
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (v1 && out_ready) void'(q1.pop_front());
            if (in_valid && r1) q1.push_back(in_pay);
            if (v0 && out_ready) void'(q0.pop_front());
            if (in_valid && r0) q0.push_back(in_pay);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({out_valid1, in_ready1, out_valid0, in_ready0} !== 4'b0101) begin
            fails++;
            $display("FAIL reset_hs: got %b want 0101", {out_valid1, in_ready1, out_valid0, in_ready0});
        end
        tests++;
        if (out1 !== '0 || out0 !== '0 || {bub1, stl1, bub0, stl0} !== 64'd0) begin
            fails++;
            $display("FAIL reset_zero: got out1=%h out0=%h cnt=%h want all 0", out1, out0, {bub1, stl1, bub0, stl0});
        end
        rst = 1'b0;
        model_reset();
        in_pay = '0;
        in_pay.alu = 32'h1234;
        in_pay.wc = 2'b11;
        in_pay.fpw = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_valid1 !== 1'b1 || alu1 !== 32'h1234 || wc1 !== 2'b11) begin
            fails++;
            $display("FAIL reset_preload: got v=%b alu=%h wc=%b want 1 1234 11", out_valid1, alu1, wc1);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({out_valid1, wc1, in_ready1, out_valid0, wc0, in_ready0} !== 8'b0001_0001) begin
            fails++;
            $display("FAIL reset_async: got %b want 00010001", {out_valid1, wc1, in_ready1, out_valid0, wc0, in_ready0});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        tests++;
        if (out1 !== '0 || out0 !== '0 || out_valid1 !== 1'b0 || {bub1, stl1} !== 32'd0) begin
            fails++;
            $display("FAIL reset_after: got out1=%h v=%b cnt=%h want 0", out1, out_valid1, {bub1, stl1});
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_pay = rand_pay();
            in_pay.alu = 32'hA0 + 32'(i);
            in_valid = 1'b1;
            tick();
            tests++;
            if (out_valid1 !== 1'b1 || alu1 !== 32'hA0 + 32'(i) || out_valid0 !== 1'b1 || alu0 !== 32'hA0 + 32'(i)) begin
                fails++;
                $display("FAIL stream_%0d: got v1=%b alu1=%h v0=%b alu0=%h want 1 %h", i, out_valid1, alu1, out_valid0, alu0, 32'hA0 + 32'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
            fails++;
            $display("FAIL stream_drain: got v1=%b v0=%b want 0 0", out_valid1, out_valid0);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_pay = rand_pay();
        in_pay.alu = 32'hB0;
        in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        in_pay = rand_pay();
        in_pay.alu = 32'hB1;
        #1;
        tests++;
        if (in_ready1 !== 1'b1) begin
            fails++;
            $display("FAIL bp_ready_one: got %b want 1", in_ready1);
        end
        tick();
        tests++;
        if (in_ready1 !== 1'b0 || out_valid1 !== 1'b1 || alu1 !== 32'hB0) begin
            fails++;
            $display("FAIL bp_two: got rdy=%b v=%b alu=%h want 0 1 b0", in_ready1, out_valid1, alu1);
        end
        in_pay = rand_pay();
        in_pay.alu = 32'hB2;
        tick();
        tests++;
        if (in_ready1 !== 1'b0 || alu1 !== 32'hB0) begin
            fails++;
            $display("FAIL bp_hold: got rdy=%b alu=%h want 0 b0", in_ready1, alu1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid1 !== 1'b1 || alu1 !== 32'hB1 || in_ready1 !== 1'b1) begin
            fails++;
            $display("FAIL bp_skid_out: got v=%b alu=%h rdy=%b want 1 b1 1", out_valid1, alu1, in_ready1);
        end
        tick();
        tests++;
        if (out_valid1 !== 1'b0) begin
            fails++;
            $display("FAIL bp_empty: got v=%b want 0", out_valid1);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pay = rand_pay();
        in_pay.alu = 32'hC0;
        tick();
        in_pay = rand_pay();
        in_pay.alu = 32'hC1;
        tick();
        flush = 1'b1;
        in_pay = rand_pay();
        in_pay.alu = 32'hCF;
        in_pay.wc = 2'b11;
        in_pay.fpw = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (out_valid1 !== 1'b0 || fpw1 !== 1'b0 || wc1 !== 2'b00 || alu1 !== 32'hC0) begin
            fails++;
            $display("FAIL flush_two: got v=%b fpw=%b wc=%b alu=%h want 0 0 00 c0", out_valid1, fpw1, wc1, alu1);
        end
        tick();
        tests++;
        if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
            fails++;
            $display("FAIL flush_no_ghost: got v1=%b v0=%b want 0 0", out_valid1, out_valid0);
        end
        in_valid = 1'b1;
        in_pay = rand_pay();
        in_pay.alu = 32'hE0;
        tick();
        flush = 1'b1;
        in_pay = rand_pay();
        in_pay.alu = 32'hE1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        tests++;
        if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
            fails++;
            $display("FAIL flush_discard: got v1=%b v0=%b want 0 0", out_valid1, out_valid0);
        end
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pay = rand_pay();
        tick();
        in_valid = 1'b0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int i = 0; i < 70000; i++) tick();
        tests++;
        if (stl1 !== 16'hFFFF || stl0 !== 16'hFFFF || bub1 !== 16'h0000) begin
            fails++;
            $display("FAIL stall_sat: got stl1=%h stl0=%h bub1=%h want ffff ffff 0000", stl1, stl0, bub1);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        tests++;
        if (stl1 !== 16'h0000 || stl0 !== 16'h0000) begin
            fails++;
            $display("FAIL stall_clr: got stl1=%h stl0=%h want 0000", stl1, stl0);
        end
        tick();
        tests++;
        if (stl1 !== 16'h0001 || 32'(stl1) !== ms1) begin
            fails++;
            $display("FAIL stall_resume: got %h want 0001", stl1);
        end
    endtask

    task automatic test_single_entry();
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pay = rand_pay();
        in_pay.alu = 32'hD0;
        tick();
        in_pay = rand_pay();
        in_pay.alu = 32'hD1;
        #1;
        tests++;
        if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
            fails++;
            $display("FAIL single_block: got v=%b rdy=%b want 1 0", out_valid0, in_ready0);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready0 !== 1'b1) begin
            fails++;
            $display("FAIL single_comb_ready: got %b want 1", in_ready0);
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            tests++;
            if (out_valid0 !== 1'b1 || alu0 !== 32'hD0 + 32'(i)) begin
                fails++;
                $display("FAIL single_b2b_%0d: got v=%b alu=%h want 1 %h", i, out_valid0, alu0, 32'hD0 + 32'(i));
            end
            in_pay = rand_pay();
            in_pay.alu = 32'hD1 + 32'(i);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random(input int n);
        bit bad;
        bit ev1, er1, ev0, er0;
        for (int i = 0; i < n; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cnt_clr   = ($urandom_range(0, 29) == 0);
            in_pay    = rand_pay();
            #1;
            ev1 = q1.size() > 0;
            er1 = q1.size() < 2;
            ev0 = q0.size() > 0;
            er0 = (q0.size() == 0) || out_ready;
            tests++;
            if ({out_valid1, in_ready1, out_valid0, in_ready0} !== {ev1, er1, ev0, er0}) begin
                fails++;
                $display("FAIL rand_hs cyc %0d: got %b want %b", i, {out_valid1, in_ready1, out_valid0, in_ready0}, {ev1, er1, ev0, er0});
            end
            tests++;
            if (ev1) bad = (out1 !== q1[0]);
            else     bad = ({wc1, fpw1} !== 3'b000);
            if (bad) begin
                fails++;
                $display("FAIL rand_pay1 cyc %0d: got %h want head of %0d-entry queue", i, out1, q1.size());
            end
            tests++;
            if (ev0) bad = (out0 !== q0[0]);
            else     bad = ({wc0, fpw0} !== 3'b000);
            if (bad) begin
                fails++;
                $display("FAIL rand_pay0 cyc %0d: got %h want head of %0d-entry queue", i, out0, q0.size());
            end
            tests++;
            if ({bub1, stl1, bub0, stl0} !== {16'(mb1), 16'(ms1), 16'(mb0), 16'(ms0)}) begin
                fails++;
                $display("FAIL rand_cnt cyc %0d: got %h want %h", i, {bub1, stl1, bub0, stl0}, {16'(mb1), 16'(ms1), 16'(mb0), 16'(ms0)});
            end
            tick();
        end
        flush = 1'b0;
        cnt_clr = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_stream();
        test_back_to_back();
        test_flush();
        test_single_entry();
        test_random(400);
        test_saturate();
        test_random(100);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
